// File: rtl/board_state.sv
// board_state: authoritative connect-four grid, column fill counts and turn flag feeding the minimax AI.
// Define BOARD_UNDO_EN to add an undo_i port backed by a one-entry move history.
module board_state #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               sw_i,
  input  logic               new_game_i,
  input  logic [2:0]         col_sel_i,
  input  logic               drop_i,
  input  logic               ai_move_i,
  input  logic [6:0]         ai_opt_i,
`ifdef BOARD_UNDO_EN
  input  logic               undo_i,
`endif
  output logic [ROWS*14-1:0] grid_o,
  output logic [COLS*3-1:0]  column_counts_o,
  output logic               player_o,
  output logic               busy_o,
  output logic               move_ack_o,
  output logic               move_err_o,
  output logic               game_over_o,
  output logic [1:0]         winner_o
);

  typedef enum logic [1:0] {IDLE, PLACE, CHECK} state_e;

  state_e             state_q, state_d;
  logic [ROWS*14-1:0] grid_q, grid_d;
  logic [COLS*3-1:0]  count_q, count_d;
  logic               player_q, player_d;
  logic               moveAck_q, moveAck_d;
  logic               moveErr_q, moveErr_d;
  logic               gameOver_q, gameOver_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         colour_q, colour_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [1:0]         dir_q, dir_d;
  logic               minusSide_q, minusSide_d;
  logic [1:0]         step_q, step_d;
  logic [2:0]         matched_q, matched_d;
`ifdef BOARD_UNDO_EN
  logic               histValid_q, histValid_d;
  logic [2:0]         histCol_q, histCol_d;
  logic               histPlayer_q, histPlayer_d;
`endif

  logic undoReq, humanReq, aiReq, probeOnBoard, probeHit, allFull;
  int   aiRow, aiCol, aiCount, humanCount, rowStep, colStep, probeRow, probeCol;

`ifdef BOARD_UNDO_EN
  assign undoReq = undo_i;
`else
  assign undoReq = 1'b0;
`endif

  // Cell (r,c) occupies bits [13-2c+14r -: 2], so its lsb sits at 14r+12-2c.
  function automatic int cellLsb(input int r, input int c);
    return 14 * r + 12 - 2 * c;
  endfunction

  function automatic logic [2:0] countOf(input logic [COLS*3-1:0] counts, input int c);
    return counts[3*c +: 3];
  endfunction

  always_comb begin
    state_d     = state_q;
    grid_d      = grid_q;
    count_d     = count_q;
    player_d    = player_q;
    moveAck_d   = 1'b0;
    moveErr_d   = 1'b0;
    gameOver_d  = gameOver_q;
    winner_d    = winner_q;
    colour_d    = colour_q;
    row_d       = row_q;
    col_d       = col_q;
    dir_d       = dir_q;
    minusSide_d = minusSide_q;
    step_d      = step_q;
    matched_d   = matched_q;
`ifdef BOARD_UNDO_EN
    histValid_d  = histValid_q;
    histCol_d    = histCol_q;
    histPlayer_d = histPlayer_q;
`endif

    humanReq   = drop_i && (!player_q || !sw_i);
    aiReq      = ai_move_i && player_q && sw_i;
    aiRow      = int'(ai_opt_i) / 14;
    aiCol      = (13 - int'(ai_opt_i) % 14) / 2;
    aiCount    = int'(countOf(count_q, aiCol));
    humanCount = (int'(col_sel_i) < COLS) ? int'(countOf(count_q, int'(col_sel_i))) : ROWS;

    // Probe walker: direction 0 horizontal, 1 vertical, 2 rising diagonal, 3 falling diagonal.
    rowStep = (dir_q == 2'd0) ? 0 : 1;
    colStep = (dir_q == 2'd1) ? 0 : ((dir_q == 2'd3) ? -1 : 1);
    if (minusSide_q) begin
      rowStep = -rowStep;
      colStep = -colStep;
    end
    probeRow     = int'(row_q) + rowStep * int'(step_q);
    probeCol     = int'(col_q) + colStep * int'(step_q);
    probeOnBoard = (probeRow >= 0) && (probeRow < ROWS) && (probeCol >= 0) && (probeCol < COLS);
    probeHit     = 1'b0;
    if (probeOnBoard) probeHit = (grid_q[cellLsb(probeRow, probeCol) +: 2] == colour_q);

    allFull = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (int'(count_q[3*c +: 3]) != ROWS) allFull = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (undoReq) begin
`ifdef BOARD_UNDO_EN
          if (histValid_q) begin
            count_d[3*int'(histCol_q) +: 3] = count_q[3*int'(histCol_q) +: 3] - 3'd1;
            grid_d[cellLsb(int'(count_q[3*int'(histCol_q) +: 3]) - 1, int'(histCol_q)) +: 2] = 2'b00;
            player_d    = histPlayer_q;
            gameOver_d  = 1'b0;
            winner_d    = 2'b00;
            histValid_d = 1'b0;
            moveAck_d   = 1'b1;
          end else begin
            moveErr_d = 1'b1;
          end
`endif
        end else if (!gameOver_q && (humanReq || aiReq)) begin
          if (humanReq ? (humanCount >= ROWS)
                       : (!ai_opt_i[0] || int'(ai_opt_i) > ROWS*14-1 || aiRow != aiCount)) begin
            moveErr_d = 1'b1;
          end else begin
            row_d     = humanReq ? 3'(humanCount) : 3'(aiRow);
            col_d     = humanReq ? col_sel_i : 3'(aiCol);
            colour_d  = player_q ? 2'b10 : 2'b01;
            moveAck_d = 1'b1;
            state_d   = PLACE;
`ifdef BOARD_UNDO_EN
            histValid_d  = 1'b1;
            histCol_d    = humanReq ? col_sel_i : 3'(aiCol);
            histPlayer_d = player_q;
`endif
          end
        end
      end

      PLACE: begin
        grid_d[cellLsb(int'(row_q), int'(col_q)) +: 2] = colour_q;
        if (int'(countOf(count_q, int'(col_q))) < ROWS)
          count_d[3*int'(col_q) +: 3] = countOf(count_q, int'(col_q)) + 3'd1;
        dir_d       = 2'd0;
        minusSide_d = 1'b0;
        step_d      = 2'd1;
        matched_d   = 3'd0;
        state_d     = CHECK;
      end

      CHECK: begin
        if (probeHit && (int'(matched_q) + 2 >= WIN_LEN)) begin
          gameOver_d = 1'b1;
          winner_d   = colour_q;
          state_d    = IDLE;
        end else if (probeHit && (int'(step_q) < WIN_LEN - 1)) begin
          matched_d = matched_q + 3'd1;
          step_d    = step_q + 2'd1;
        end else begin
          // The current side ended; run count carries from + side into - side only.
          matched_d = probeHit ? matched_q + 3'd1 : matched_q;
          step_d    = 2'd1;
          if (!minusSide_q) begin
            minusSide_d = 1'b1;
          end else begin
            matched_d   = 3'd0;
            minusSide_d = 1'b0;
            if (dir_q == 2'd3) begin
              state_d = IDLE;
              if (allFull) begin
                gameOver_d = 1'b1;
                winner_d   = 2'b11;
              end else begin
                player_d = ~player_q;
              end
            end else begin
              dir_d = dir_q + 2'd1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || new_game_i) begin
      state_q     <= IDLE;
      grid_q      <= '0;
      count_q     <= '0;
      player_q    <= 1'b0;
      moveAck_q   <= 1'b0;
      moveErr_q   <= 1'b0;
      gameOver_q  <= 1'b0;
      winner_q    <= 2'b00;
      colour_q    <= 2'b00;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      dir_q       <= 2'd0;
      minusSide_q <= 1'b0;
      step_q      <= 2'd1;
      matched_q   <= 3'd0;
`ifdef BOARD_UNDO_EN
      histValid_q  <= 1'b0;
      histCol_q    <= 3'd0;
      histPlayer_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grid_q      <= grid_d;
      count_q     <= count_d;
      player_q    <= player_d;
      moveAck_q   <= moveAck_d;
      moveErr_q   <= moveErr_d;
      gameOver_q  <= gameOver_d;
      winner_q    <= winner_d;
      colour_q    <= colour_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dir_q       <= dir_d;
      minusSide_q <= minusSide_d;
      step_q      <= step_d;
      matched_q   <= matched_d;
`ifdef BOARD_UNDO_EN
      histValid_q  <= histValid_d;
      histCol_q    <= histCol_d;
      histPlayer_q <= histPlayer_d;
`endif
    end
  end

  assign grid_o          = grid_q;
  assign column_counts_o = count_q;
  assign player_o        = player_q;
  assign busy_o          = (state_q != IDLE);
  assign move_ack_o      = moveAck_q;
  assign move_err_o      = moveErr_q;
  assign game_over_o     = gameOver_q;
  assign winner_o        = winner_q;

endmodule

// File: doc/board_state.md
Name: board_state

Overview:
- Connect-four board owner; sits directly upstream of the minimax AI.
- Holds the authoritative 6x7 grid, per-column fill counts and turn flag. Feeds grid, column_counts and player to the AI.
- Accepts drops from the human (column select + pulse) or from the AI (move pulse + cell index).
- Validates each drop, places the piece, runs a sequential four-in-a-row check around the new piece, then either ends the game or hands over the turn.

Parameters:
- ROWS, 6, board rows; grid width is ROWS*14.
- COLS, 7, board columns; fixed by the cell encoding. Only 7 is supported.
- WIN_LEN, 4, run length that wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sw  in  1  1 = AI mode (player 1 moves via ai_move); 0 = two-human mode
- new_game  in  1  single-cycle pulse; clears the board (same effect as reset)
- col_sel  in  3  human column select, 0..6
- drop  in  1  single-cycle pulse, debounced upstream; requests a human drop into col_sel
- ai_move  in  1  single-cycle pulse from the AI
- ai_opt  in  7  AI chosen cell, given as the msb index of the cell in grid
- grid  out  84  cell (row r, col c) = bits [13-2c+14r -: 2]; 00 empty, 01 player 0, 10 player 1
- column_counts  out  21  col c fill count = bits [3c+2 -: 3], range 0..6
- player  out  1  side to move; 0 = human, 1 = AI/second human
- busy  out  1  high while in PLACE or CHECK
- move_ack  out  1  one-cycle pulse on each accepted drop
- move_err  out  1  one-cycle pulse on each rejected drop
- game_over  out  1  sticky until rst_n or new_game
- winner  out  2  00 none, 01 player 0, 10 player 1, 11 draw

Behaviour:
- Reset state (rst_n low at posedge, or new_game): grid=0, column_counts=0, player=0, busy=0, move_ack=0, move_err=0, game_over=0, winner=00, FSM=IDLE. new_game has priority over all other inputs.
- State IDLE, accepting drops, under these rules:
  - drop is accepted when player==0, or when player==1 and sw==0.
  - ai_move is accepted only when player==1 and sw==1.
  - drop and ai_move asserted together: the request legal for the current player is taken; the other is ignored silently.
  - Any request while game_over, or while busy, is ignored (no err pulse).
- AI index decode: col = (13 - ai_opt%14)/2, row = ai_opt/14. Decode is done in full-width arithmetic.
- Validation, checked at the request cycle:
  - Human: reject if col_sel>6 or count[col_sel]==6.
  - AI: reject if ai_opt is even, ai_opt>83, or row != count[col].
  - Reject: move_err pulses the next cycle; state, player and grid are unchanged.
- Transition IDLE -> PLACE, one cycle:
  - Write the player code (01 or 10) into cell (row = count[col], col).
  - Increment count[col]; count never wraps past 6.
  - Latch row, col and colour; pulse move_ack.
- State CHECK: one board cell examined per cycle.
  - Directions in order: horizontal, vertical, diagonal (+row,+col), diagonal (+row,-col).
  - For each direction, walk the + side for steps 1..WIN_LEN-1, then the - side.
  - A side stops early on an off-board cell or a colour mismatch.
  - Win when 1 + matched cells >= WIN_LEN. Stop immediately.
  - Worst-case CHECK length is 24 cycles.
- CHECK -> IDLE on completion:
  - Win: game_over=1, winner=colour code; player not toggled.
  - Else, if all column_counts are 6: game_over=1, winner=11.
  - Else: player toggles.
- grid and player are stable for the whole of IDLE. The AI needs at least 106 stable cycles, and player toggling to 1 restarts it.
- Reset or new_game mid-CHECK aborts the check and returns to IDLE with the reset values.

Optional Feature:
- Macro: BOARD_UNDO_EN.
- Defined:
  - Extra input undo (single-cycle pulse).
  - A one-entry history holds the last accepted column and the player before that move.
  - undo in IDLE with valid history, and not mid-check: decrement that column count, clear its top cell, restore player, clear game_over and winner, invalidate history; pulse move_ack.
  - undo with empty history: pulse move_err.
- Not defined: no undo port and no history registers.

Test Plan:
- Reset then drop col_sel=3 -> grid[49:48]... cell (0,3) bits[7:6]=01, count3=1, move_ack, busy high <=26 cycles, then player=1.
- sw=1, player=1, ai_move with ai_opt=21 (row1,col3) and count3=1 -> bits[21:20]=10, player returns to 0.
- ai_opt=35 while count3=1 (row mismatch) -> move_err pulse, grid unchanged, player stays 1.
- Player 0 on cols 0,1,2,3 row 0, interleaved with player 1 on col 6 -> after the 4th drop game_over=1, winner=01, player stays 0.
- Fill column 2 to 6, then drop col_sel=2 -> move_err; no count wrap.
- Filling all 42 cells with no line -> winner=11. new_game mid-CHECK -> all outputs at reset values next cycle.
